// File: rtl/async_fifo_levels.sv
// async_fifo_levels: dual-clock Gray-pointer FIFO with per-domain fill levels,
// programmable almost-full/almost-empty, registered read data and sticky error flags.
module async_fifo_levels #(
  parameter int DATASIZE    = 12,
  parameter int ADDRSIZE    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_LVL   = (1 << ADDRSIZE) - 4,
  parameter int AEMPTY_LVL  = 4
) (
  input  logic                write_clk,
  input  logic                read_reset_n,
  input  logic                write_reset_n,
  input  logic                read_clk,
  input  logic                write_enable,
  input  logic [DATASIZE-1:0] write_data,
  output logic                write_full,
  output logic                almost_full,
  output logic [ADDRSIZE:0]   wr_level,
  output logic                overflow,
  input  logic                wr_err_clr,
  input  logic                read_enable,
  output logic [DATASIZE-1:0] read_data,
  output logic                read_valid,
  output logic                read_empty,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   rd_level,
  output logic                underflow,
  input  logic                rd_err_clr
);
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int PW    = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AFULL_TH  = PW'(AFULL_LVL);
  localparam logic [ADDRSIZE:0] AEMPTY_TH = PW'(AEMPTY_LVL);

  // Handshake: write_enable/read_enable are requests qualified by ~write_full/~read_empty.
  // A request against a full/empty FIFO is dropped and raises the sticky error flag;
  // read_valid is high for exactly the cycle read_data carries a newly popped word.

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATASIZE-1:0] mem [DEPTH];

  // Reset synchronisers: assertion is immediate, release is aligned to the local clock.
  logic [1:0] wrst_sync;
  logic [1:0] rrst_sync;
  logic       wrst_n;
  logic       rrst_n;

  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) wrst_sync <= '0;
    else                wrst_sync <= {wrst_sync[0], 1'b1};
  end

  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) rrst_sync <= '0;
    else               rrst_sync <= {rrst_sync[0], 1'b1};
  end

  assign wrst_n = wrst_sync[1];
  assign rrst_n = rrst_sync[1];

  // ---------------- write domain ----------------
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wgray;
  logic [ADDRSIZE:0] rgray;
  logic [SYNC_STAGES-1:0][ADDRSIZE:0] rgray_sync;
  logic              push;
  logic [ADDRSIZE:0] wbin_next;
  logic [ADDRSIZE:0] wgray_next;
  logic [ADDRSIZE:0] rgray_w;
  logic [ADDRSIZE:0] rbin_w;
  logic [ADDRSIZE:0] wlevel_next;
  logic              full_next;

  assign push        = write_enable & ~write_full;
  assign wbin_next   = wbin + PW'(push);
  assign wgray_next  = bin2gray(wbin_next);
  assign rgray_w     = rgray_sync[SYNC_STAGES-1];
  assign rbin_w      = gray2bin(rgray_w);
  assign wlevel_next = wbin_next - rbin_w;
  // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
  assign full_next   = (wgray_next == {~rgray_w[ADDRSIZE:ADDRSIZE-1], rgray_w[ADDRSIZE-2:0]});

  always_ff @(posedge write_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      rgray_sync  <= '0;
      wbin        <= '0;
      wgray       <= '0;
      write_full  <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      rgray_sync  <= {rgray_sync[SYNC_STAGES-2:0], rgray};
      wbin        <= wbin_next;
      wgray       <= wgray_next;
      write_full  <= full_next;
      almost_full <= (wlevel_next >= AFULL_TH);
      wr_level    <= wlevel_next;
      if (write_enable && write_full) overflow <= 1'b1;
      else if (wr_err_clr)            overflow <= 1'b0;
    end
  end

  always_ff @(posedge write_clk) begin
    if (push) mem[wbin[ADDRSIZE-1:0]] <= write_data;
  end

  // ---------------- read domain ----------------
  logic [ADDRSIZE:0] rbin;
  logic [SYNC_STAGES-1:0][ADDRSIZE:0] wgray_sync;
  logic              pop;
  logic [ADDRSIZE:0] rbin_next;
  logic [ADDRSIZE:0] rgray_next;
  logic [ADDRSIZE:0] wgray_r;
  logic [ADDRSIZE:0] wbin_r;
  logic [ADDRSIZE:0] rlevel_next;

  assign pop         = read_enable & ~read_empty;
  assign rbin_next   = rbin + PW'(pop);
  assign rgray_next  = bin2gray(rbin_next);
  assign wgray_r     = wgray_sync[SYNC_STAGES-1];
  assign wbin_r      = gray2bin(wgray_r);
  assign rlevel_next = wbin_r - rbin_next;

  always_ff @(posedge read_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      wgray_sync   <= '0;
      rbin         <= '0;
      rgray        <= '0;
      read_empty   <= 1'b1;
      almost_empty <= 1'b1;
      rd_level     <= '0;
      read_valid   <= 1'b0;
      read_data    <= '0;
      underflow    <= 1'b0;
    end else begin
      wgray_sync   <= {wgray_sync[SYNC_STAGES-2:0], wgray};
      rbin         <= rbin_next;
      rgray        <= rgray_next;
      read_empty   <= (rgray_next == wgray_r);
      almost_empty <= (rlevel_next <= AEMPTY_TH);
      rd_level     <= rlevel_next;
      read_valid   <= pop;
      if (pop) read_data <= mem[rbin[ADDRSIZE-1:0]];
      if (read_enable && read_empty) underflow <= 1'b1;
      else if (rd_err_clr)           underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_async_fifo_levels.sv
// tb_async_fifo_levels: random and directed traffic against a queue reference model;
// monitors on each clock pop/compare data and track the sticky error flags.
module tb_async_fifo_levels;
  localparam int DW    = 12;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          write_clk = 1'b0;
  logic          read_clk  = 1'b0;
  logic          read_reset_n, write_reset_n;
  logic          write_enable, wr_err_clr, read_enable, rd_err_clr;
  logic [DW-1:0] write_data;
  logic          write_full, almost_full, overflow;
  logic          read_valid, read_empty, almost_empty, underflow;
  logic [AW:0]   wr_level, rd_level;
  logic [DW-1:0] read_data;

  int            vectors     = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];
  bit            exp_ovf = 1'b0;
  bit            exp_udf = 1'b0;
  bit            rd_acc  = 1'b0;
  logic [DW-1:0] last_data = '0;

  // ---------------- clock / reset ----------------
  always #10 write_clk = ~write_clk;
  always #27 read_clk  = ~read_clk;

  async_fifo_levels dut (
    .write_clk(write_clk), .read_reset_n(read_reset_n), .write_reset_n(write_reset_n),
    .read_clk(read_clk), .write_enable(write_enable), .write_data(write_data),
    .write_full(write_full), .almost_full(almost_full), .wr_level(wr_level),
    .overflow(overflow), .wr_err_clr(wr_err_clr), .read_enable(read_enable),
    .read_data(read_data), .read_valid(read_valid), .read_empty(read_empty),
    .almost_empty(almost_empty), .rd_level(rd_level), .underflow(underflow),
    .rd_err_clr(rd_err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge write_clk) begin
    if (!write_reset_n) begin
      exp_ovf = 1'b0;
    end else begin
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("wr_level_cap", 32'(wr_level <= 9'(DEPTH)), 32'd1);
      if (write_enable && !write_full) exp_q.push_back(write_data);
      if (write_enable && write_full) exp_ovf = 1'b1;
      else if (wr_err_clr)            exp_ovf = 1'b0;
    end
  end

  always @(negedge read_clk) begin
    if (!read_reset_n) begin
      rd_acc    = 1'b0;
      exp_udf   = 1'b0;
      last_data = '0;
    end else begin
      chk("read_valid", 32'(read_valid), 32'(rd_acc));
      if (read_valid) begin
        if (exp_q.size() == 0) fail_now("read_data_unexpected");
        else begin
          last_data = exp_q.pop_front();
          chk("read_data", 32'(read_data), 32'(last_data));
        end
      end else begin
        chk("read_data_hold", 32'(read_data), 32'(last_data));
      end
      chk("underflow", 32'(underflow), 32'(exp_udf));
      chk("rd_level_cap", 32'(rd_level <= 9'(DEPTH)), 32'd1);
      rd_acc = read_enable && !read_empty;
      if (read_enable && read_empty) exp_udf = 1'b1;
      else if (rd_err_clr)           exp_udf = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_check();
    chk("rst_write_full", 32'(write_full), 32'd0);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_wr_level", 32'(wr_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_read_empty", 32'(read_empty), 32'd1);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("rst_rd_level", 32'(rd_level), 32'd0);
    chk("rst_read_valid", 32'(read_valid), 32'd0);
    chk("rst_read_data", 32'(read_data), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    @(posedge write_clk); #1;
    write_enable = 1'b1;
    write_data   = d;
    @(posedge write_clk); #1;
    write_enable = 1'b0;
  endtask

  task automatic pop_n(input int n);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 4000) begin
      @(posedge read_clk); #1;
      read_enable = 1'b1;
      if (!read_empty) got++;
      cyc++;
    end
    @(posedge read_clk); #1;
    read_enable = 1'b0;
    if (got < n) fail_now("pop_timeout");
  endtask

  // Idle long enough for both pointer synchronisers, then compare levels/flags to the model.
  task automatic settle_check();
    int n;
    repeat (12) @(posedge read_clk);
    @(negedge read_clk); #1;
    n = exp_q.size();
    chk("wr_level", 32'(wr_level), 32'(n));
    chk("rd_level", 32'(rd_level), 32'(n));
    chk("write_full", 32'(write_full), 32'(n == DEPTH));
    chk("read_empty", 32'(read_empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= DEPTH - 4));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 4));
  endtask

  task automatic stream(input int n, input int wpct, input int rpct);
    fork
      begin : writer
        int sent;
        int cyc;
        bit en;
        sent = 0;
        cyc  = 0;
        while (sent < n && cyc < 40000) begin
          @(posedge write_clk); #1;
          en = ($urandom_range(99) < wpct);
          write_enable = en;
          write_data   = 12'($urandom_range(4095));
          if (en && !write_full) sent++;
          cyc++;
        end
        @(posedge write_clk); #1;
        write_enable = 1'b0;
        if (sent < n) fail_now("stream_write_timeout");
      end
      begin : reader
        int got;
        int cyc;
        bit en;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 20000) begin
          @(posedge read_clk); #1;
          en = ($urandom_range(99) < rpct);
          read_enable = en;
          if (en && !read_empty) got++;
          cyc++;
        end
        @(posedge read_clk); #1;
        read_enable = 1'b0;
        if (got < n) fail_now("stream_read_timeout");
      end
    join
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    write_enable  = 1'b0;
    write_data    = '0;
    wr_err_clr    = 1'b0;
    read_enable   = 1'b0;
    rd_err_clr    = 1'b0;
    write_reset_n = 1'b0;
    read_reset_n  = 1'b0;
    #50;
    reset_check();
    #7  write_reset_n = 1'b1;
    #13 read_reset_n  = 1'b1;
    repeat (6) @(posedge read_clk);

    // in-order transfer of 1..8, then almost_empty threshold on the way down
    for (int i = 1; i <= 8; i++) push_word(12'(i));
    settle_check();
    pop_n(3);
    settle_check();
    pop_n(1);
    settle_check();
    pop_n(4);
    settle_check();

    // pop on empty raises underflow until cleared
    @(posedge read_clk); #1 read_enable = 1'b1;
    @(posedge read_clk); #1 read_enable = 1'b0;
    repeat (2) @(negedge read_clk);
    #1 chk("underflow_set", 32'(underflow), 32'd1);
    chk("underflow_rd_level", 32'(rd_level), 32'd0);
    @(posedge read_clk); #1 rd_err_clr = 1'b1;
    @(posedge read_clk); #1 rd_err_clr = 1'b0;
    @(negedge read_clk); #1 chk("underflow_clr", 32'(underflow), 32'd0);
    settle_check();

    // fill to DEPTH with back-to-back pushes, level and flags tracked per word
    @(posedge write_clk); #1;
    write_enable = 1'b1;
    write_data   = 12'($urandom_range(4095));
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge write_clk); #1;
      if (k < DEPTH) write_data = 12'($urandom_range(4095));
      else           write_enable = 1'b0;
      @(negedge write_clk);
      chk("fill_wr_level", 32'(wr_level), 32'(k));
      chk("fill_almost_full", 32'(almost_full), 32'(k >= DEPTH - 4));
      chk("fill_write_full", 32'(write_full), 32'(k == DEPTH));
    end
    push_word(12'hFFF);
    @(negedge write_clk); #1 chk("overflow_set", 32'(overflow), 32'd1);
    @(posedge write_clk); #1 wr_err_clr = 1'b1;
    @(posedge write_clk); #1 wr_err_clr = 1'b0;
    @(negedge write_clk); #1 chk("overflow_clr", 32'(overflow), 32'd0);
    settle_check();
    pop_n(DEPTH);
    settle_check();

    // random streaming, slow writer then slow reader
    stream(700, 25, 75);
    settle_check();
    stream(700, 75, 25);
    settle_check();

    // both resets mid-stream, then a fresh stream of 0xABC
    for (int i = 0; i < 20; i++) push_word(12'($urandom_range(4095)));
    pop_n(5);
    #3;
    read_reset_n  = 1'b0;
    write_reset_n = 1'b0;
    #40;
    reset_check();
    repeat (3) @(posedge read_clk);
    exp_q.delete();
    #11 read_reset_n  = 1'b1;
    #17 write_reset_n = 1'b1;
    repeat (6) @(posedge read_clk);
    for (int i = 0; i < 10; i++) push_word(12'hABC);
    settle_check();
    pop_n(10);
    settle_check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
